fnd_scan_controller: RTL

Time-multiplexing scan controller for the 4-digit BCD-to-FND display path. It holds a 16-bit packed BCD display word and rotates through the four digits at a programmable refresh rate. Each slot drives the display decoder's enable, 2-bit digit select and 4-bit BCD value. A shadow-register load handshake prevents tearing, updates are applied only at frame boundaries, and optional leading-zero blanking is supported.

---
 rtl/fnd_scan_controller.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/fnd_scan_controller.sv
`default_nettype none
// ============================================================================
// Module      : fnd_scan_controller
// Description : Four-digit time-multiplexed FND scan controller with a
//               tear-free shadow load and optional leading-zero blanking.
// Revision    : 1.0 - initial release
// ============================================================================

module fnd_scan_controller #(
    parameter int CLK_DIV = 100000
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_En,
    input  logic        i_Load,
    input  logic [15:0] i_Value,
    input  logic        i_BlankLZ,
    output logic        o_En,
    output logic [1:0]  o_DigitSelect,
    output logic [3:0]  o_Value,
    output logic        o_Pending,
    output logic        o_FrameDone
);

    localparam int                 c_CNT_W   = $clog2(CLK_DIV);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(CLK_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

    typedef enum logic [0:0] {
        c_ST_IDLE = 1'b0,
        c_ST_SCAN = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_CNT_W-1:0] r_count;
    logic [c_CNT_W-1:0] w_count_nxt;
    logic [1:0]         r_idx;
    logic [1:0]         w_idx_nxt;
    logic [15:0]        r_disp;
    logic [15:0]        w_disp_nxt;
    logic [15:0]        r_shadow;
    logic [15:0]        w_shadow_nxt;
    logic               r_pending;
    logic               w_pending_nxt;
    logic               r_frame_done;
    logic               w_frame_done_nxt;
    logic               r_en;
    logic               w_en_nxt;
    logic [3:0]         r_val;
    logic [3:0]         w_val_nxt;

    logic               w_tick;
    logic               w_wrap;
    logic [3:0]         w_nib_zero;
    logic [3:0]         w_blank;

    assign w_tick = (r_state == c_ST_SCAN) && (r_count == c_CNT_MAX);
    assign w_wrap = w_tick && (r_idx == 2'd3);

    // ------------------------------------------------------------------
    // Next-state logic: prescaler, digit index and the load handshake
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt      = r_state;
        w_count_nxt      = r_count;
        w_idx_nxt        = r_idx;
        w_disp_nxt       = r_disp;
        w_shadow_nxt     = r_shadow;
        w_pending_nxt    = r_pending;
        w_frame_done_nxt = 1'b0;

        case (r_state)
            c_ST_IDLE: begin
                w_count_nxt   = '0;
                w_idx_nxt     = 2'd0;
                w_pending_nxt = 1'b0;
                // Nothing is on screen, so a load goes straight to the display
                if (i_Load) begin
                    w_disp_nxt   = i_Value;
                    w_shadow_nxt = i_Value;
                end
                if (i_En) begin
                    w_state_nxt = c_ST_SCAN;
                end
            end

            c_ST_SCAN: begin
                if (w_tick) begin
                    w_count_nxt = '0;
                    w_idx_nxt   = r_idx + 2'd1;
                end else begin
                    w_count_nxt = r_count + c_CNT_ONE;
                end
                w_frame_done_nxt = w_wrap;

                if (!i_En) begin
                    // Leaving the scan flushes any held value into the display
                    w_state_nxt   = c_ST_IDLE;
                    w_count_nxt   = '0;
                    w_idx_nxt     = 2'd0;
                    w_pending_nxt = 1'b0;
                    if (i_Load) begin
                        w_disp_nxt   = i_Value;
                        w_shadow_nxt = i_Value;
                    end else if (r_pending) begin
                        w_disp_nxt = r_shadow;
                    end
                end else if (w_wrap) begin
                    w_pending_nxt = 1'b0;
                    if (i_Load) begin
                        w_disp_nxt   = i_Value;
                        w_shadow_nxt = i_Value;
                    end else if (r_pending) begin
                        w_disp_nxt = r_shadow;
                    end
                end else if (i_Load) begin
                    w_shadow_nxt  = i_Value;
                    w_pending_nxt = 1'b1;
                end
            end

            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode on the next-cycle values so every output is a flop
    // ------------------------------------------------------------------
    generate
        for (genvar k = 0; k < 4; k++) begin : g_nib_zero
            assign w_nib_zero[k] = (w_disp_nxt[4*k +: 4] == 4'h0);
        end
    endgenerate

    // A digit blanks only when it and every more-significant digit are zero
    assign w_blank[0] = 1'b0;
    assign w_blank[1] = i_BlankLZ && w_nib_zero[1] && w_nib_zero[2] && w_nib_zero[3];
    assign w_blank[2] = i_BlankLZ && w_nib_zero[2] && w_nib_zero[3];
    assign w_blank[3] = i_BlankLZ && w_nib_zero[3];

    assign w_en_nxt  = (w_state_nxt == c_ST_SCAN) && !w_blank[w_idx_nxt];
    assign w_val_nxt = w_disp_nxt[4*w_idx_nxt +: 4];

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state      <= c_ST_IDLE;
            r_count      <= '0;
            r_idx        <= 2'd0;
            r_disp       <= 16'h0000;
            r_shadow     <= 16'h0000;
            r_pending    <= 1'b0;
            r_frame_done <= 1'b0;
            r_en         <= 1'b0;
            r_val        <= 4'h0;
        end else begin
            r_state      <= w_state_nxt;
            r_count      <= w_count_nxt;
            r_idx        <= w_idx_nxt;
            r_disp       <= w_disp_nxt;
            r_shadow     <= w_shadow_nxt;
            r_pending    <= w_pending_nxt;
            r_frame_done <= w_frame_done_nxt;
            r_en         <= w_en_nxt;
            r_val        <= w_val_nxt;
        end
    end

    assign o_En          = r_en;
    assign o_DigitSelect = r_idx;
    assign o_Value       = r_val;
    assign o_Pending     = r_pending;
    assign o_FrameDone   = r_frame_done;

endmodule

`default_nettype wire
